// File: rtl/event_pkg.sv
// Shared types and constants for the multi-channel event sink.
// Drive and free are both active-low; idle levels are named here so the logic reads in intent.
package event_pkg;

    typedef enum logic [0:0] {
        FE_IDLE = 1'b0,
        FE_LOW  = 1'b1
    } fe_state_t;

    localparam logic FREE_ACTIVE = 1'b0;
    localparam logic DRIVE_IDLE  = 1'b1;

endpackage

// File: rtl/event_sink_chan.sv
// One sink channel: drive edge detect, DELAY-stage token delay line, backlog counter
// and a two-state free engine that emits one active-low free pulse per token.
module event_sink_chan
    import event_pkg::*;
#(
    parameter int DELAY = 2,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_drive,
    input  logic i_ovf_clr,
    output logic o_free,
    output logic o_busy,
    output logic o_ovf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_drive_q;
    logic             r_armed;
    logic [DELAY-1:0] r_dly;
    logic [CNT_W-1:0] r_cnt;
    fe_state_t        r_state;
    logic             r_free;
    logic             r_ovf;

    logic             w_event;
    logic             w_exit;
    logic             w_drain;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_nxt;

    // r_armed suppresses the first sample after reset, so a drive already low at release is no event.
    assign w_event = r_armed && (r_drive_q == DRIVE_IDLE) && (i_drive != DRIVE_IDLE);
    assign w_exit  = r_dly[DELAY-1];
    assign w_drain = (r_state == FE_IDLE) && ((r_cnt != '0) || w_exit);
    assign w_drop  = w_exit && !w_drain && (r_cnt == CNT_MAX);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_exit && !w_drain && !w_drop) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (!w_exit && w_drain) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end
    end

    generate
        if (DELAY == 1) begin : g_dly_one
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= w_event;
                end
            end
        end else begin : g_dly_many
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= {r_dly[DELAY-2:0], w_event};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drive_q <= DRIVE_IDLE;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_drive_q <= i_drive;
            r_armed   <= 1'b1;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Free engine: a pulse is always followed by at least one high cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= FE_IDLE;
            r_free  <= ~FREE_ACTIVE;
        end else begin
            case (r_state)
                FE_IDLE: begin
                    if (w_drain) begin
                        r_state <= FE_LOW;
                        r_free  <= FREE_ACTIVE;
                    end else begin
                        r_state <= FE_IDLE;
                        r_free  <= ~FREE_ACTIVE;
                    end
                end
                default: begin
                    r_state <= FE_IDLE;
                    r_free  <= ~FREE_ACTIVE;
                end
            endcase
        end
    end

    // A new overflow outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_free = r_free;
    assign o_ovf  = r_ovf;
    assign o_busy = (|r_dly) || (r_cnt != '0) || (r_state == FE_LOW);

endmodule

// File: rtl/event_sink_array.sv
// Token terminator for clocked control pipelines: CHANNELS independent event sinks
// side by side with no cross-channel interaction.
module event_sink_array
    import event_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 2,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] i_drive,
    output logic [CHANNELS-1:0] o_free,
    output logic [CHANNELS-1:0] o_busy,
    output logic [CHANNELS-1:0] o_ovf,
    input  logic [CHANNELS-1:0] i_ovf_clr
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        event_sink_chan #(
            .DELAY (DELAY),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .i_drive   (i_drive[g]),
            .i_ovf_clr (i_ovf_clr[g]),
            .o_free    (o_free[g]),
            .o_busy    (o_busy[g]),
            .o_ovf     (o_ovf[g])
        );
    end

endmodule
